face_image_sender: RTL and testbench
====================================

// Module: face_image_sender
// PURPOSE
//  Transmit side of the face_reader pixel interface: on start, reads one WIDTH x DEPTH RGB frame
//  from a 1-cycle-latency frame RAM and streams it raster-order (x fastest) into face_reader's
//  image_in_R/G/B + enable inputs. It then waits for face_reader's done and reports completion
//  or timeout. Sits between the frame-buffer RAM and face_reader in the top level.
// PARAMETERS
//  WIDTH          256    pixels per line
//  DEPTH          256    lines per frame
//  COLOR_DEPTH    8      bits per colour channel
//  ADDR_W         16     frame RAM address width; must satisfy 2**ADDR_W >= WIDTH*DEPTH
//  TIMEOUT_CYCLES 200000 max cycles in WAIT_RESULT before timeout is flagged
// PORTS
//  clk            in   1              clock; all logic on posedge
//  rst_n          in   1              asynchronous active-low reset
//  start          in   1              1-cycle request to send a frame; ignored unless idle
//  busy           out  1              high from accepted start until return to IDLE
//  mem_rd_en      out  1              frame RAM read strobe
//  mem_addr       out  ADDR_W         frame RAM address, y*WIDTH+x
//  mem_rdata      in   3*COLOR_DEPTH  {R,G,B}, valid the cycle after mem_rd_en
//  image_out_R/G/B out COLOR_DEPTH    registered pixel channels to face_reader
//  enable         out  1              1-cycle frame-start strobe to face_reader
//  done_in        in   1              face_reader done (result ready)
//  frame_complete out  1              1-cycle pulse: done_in rose within timeout
//  timeout        out  1              1-cycle pulse: TIMEOUT_CYCLES expired in WAIT_RESULT
// BEHAVIOUR
//  - Reset (async, any state): state IDLE; busy, mem_rd_en, enable, frame_complete, timeout = 0;
//    mem_addr = 0; image_out_R/G/B = 0; pixel and timeout counters cleared. Release is clean.
//  - FSM: IDLE -> PRIME -> STREAM -> DRAIN -> WAIT_RESULT -> IDLE.
//  - IDLE: start=1 sampled -> PRIME, busy=1 next cycle. start in any other state is dropped.
//  - PRIME: mem_rd_en=1, mem_addr=0; enable driven so that it is high for exactly one cycle E.
//  - Stream timing (fixed contract): image_out_* carries pixel k during cycle E+1+k,
//    k = 0..WIDTH*DEPTH-1, one pixel per cycle, no gaps, no stalls (face_reader cannot stall).
//  - STREAM: mem_addr increments by 1 per cycle with mem_rd_en=1; last address WIDTH*DEPTH-1,
//    then mem_rd_en=0. Address counter is ADDR_W bits; it never wraps past the last pixel.
//  - image_out_* = registered mem_rdata slice (R = MSBs, B = LSBs); zero in every cycle not
//    carrying a pixel, including the end-of-image cycle after the last pixel.
//  - DRAIN: one cycle after last pixel (face_reader end_of_image); outputs zero -> WAIT_RESULT.
//  - WAIT_RESULT: done_in registered once; rising edge (0->1) -> frame_complete pulse, IDLE.
//    Counter increments each cycle; at TIMEOUT_CYCLES with no edge -> timeout pulse, IDLE.
//    Edge and expiry in same cycle: frame_complete wins, timeout not asserted.
//    done_in already high on entry is not an edge; the partner deasserts done between frames.
//  - busy falls the cycle frame_complete/timeout pulses; new start accepted the next cycle.
//  - No arithmetic saturation needed; pixel count compare uses WIDTH*DEPTH-1 exactly.
// TESTING
//  1 Reset: rst_n low mid-STREAM -> same cycle all outputs 0, busy 0; next start sends pixel 0.
//  2 WIDTH=4,DEPTH=2, RAM[k]={k,k+1,k+2}: start -> enable 1 cycle, pixels 0..7 in E+1..E+8
//    exact, zero in E+9, mem_addr 0..7 once each.
//  3 done_in rises 10 cycles into WAIT_RESULT -> frame_complete 1 pulse, busy 0, timeout 0.
//  4 TIMEOUT_CYCLES=16, done_in held 0 -> timeout pulse after exactly 16 cycles, IDLE.
//  5 start held high during whole frame -> exactly one frame sent; second start post-IDLE works.
//  6 done_in high on entry, stays high -> no completion, timeout fires; low->high -> complete.

Source files
------------

// File: rtl/face_image_sender.sv
// -----------------------------------------------------------------------------
// face_image_sender
//
// Transmit side of the face_reader pixel interface. On an accepted start it
// reads one WIDTH x DEPTH RGB frame from a frame RAM with one cycle of read
// latency. It streams the frame in raster order (x fastest) into face_reader's
// image_in_R/G/B and enable inputs. It then waits for face_reader's done and
// reports either completion or timeout.
//
// Ports
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   start               1-cycle send request, only honoured in IDLE
//   busy                high from accepted start until the FSM is back in IDLE
//   mem_rd_en/mem_addr  frame RAM read strobe and address (y*WIDTH+x)
//   mem_rdata           {R,G,B} read data, valid the cycle after mem_rd_en
//   image_out_R/G/B     registered pixel channels to face_reader
//   enable              1-cycle frame-start strobe to face_reader
//   done_in             face_reader result-ready level
//   frame_complete      1-cycle pulse: done_in rose before the timeout
//   timeout             1-cycle pulse: TIMEOUT_CYCLES elapsed in WAIT_RESULT
//   state_dbg           current FSM state, for observation only
//
// Handshake semantics: there is no backpressure anywhere. start is a request
// that is sampled only in IDLE; every other cycle it is dropped. face_reader
// cannot stall, so once enable has pulsed, exactly one pixel is presented per
// cycle with no gaps. done_in is treated as a level. Only a 0->1 transition
// seen while waiting for a result counts as completion.
//
// Stream timing: let E be the cycle in which enable is high. Pixel k is on
// image_out_* during cycle E+1+k. The RAM read for pixel k is issued in cycle
// E-1+k. Data returns in cycle E+k and is registered onto the outputs for
// cycle E+1+k.
// -----------------------------------------------------------------------------
module face_image_sender #(
  parameter int WIDTH          = 256,
  parameter int DEPTH          = 256,
  parameter int COLOR_DEPTH    = 8,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [3*COLOR_DEPTH-1:0] mem_rdata,
  output logic [COLOR_DEPTH-1:0]   image_out_R,
  output logic [COLOR_DEPTH-1:0]   image_out_G,
  output logic [COLOR_DEPTH-1:0]   image_out_B,
  output logic                     enable,
  input  logic                     done_in,
  output logic                     frame_complete,
  output logic                     timeout,
  output logic [2:0]               state_dbg
);

  localparam int                 NPIX      = WIDTH * DEPTH;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam int                 TCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCNT_W-1:0]  TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam int                 PIX_W     = 3 * COLOR_DEPTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRIME  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  reading_q, reading_d;    // reads still outstanding in STREAM
  logic                  rd_valid_q, rd_valid_d;  // mem_rdata holds a pixel this cycle
  logic                  rd_last_q, rd_last_d;    // ...and it is the last pixel
  logic                  out_last_q, out_last_d;  // last pixel is on image_out_* now
  logic                  enable_q, enable_d;
  logic [PIX_W-1:0]      pix_q, pix_d;
  logic                  done_q, done_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic                  frame_complete_q, frame_complete_d;
  logic                  timeout_q, timeout_d;

  logic                  rd_en_w;
  logic                  done_rise_w;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      busy_q           <= 1'b0;
      addr_q           <= '0;
      reading_q        <= 1'b0;
      rd_valid_q       <= 1'b0;
      rd_last_q        <= 1'b0;
      out_last_q       <= 1'b0;
      enable_q         <= 1'b0;
      pix_q            <= '0;
      done_q           <= 1'b0;
      tcnt_q           <= '0;
      frame_complete_q <= 1'b0;
      timeout_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      busy_q           <= busy_d;
      addr_q           <= addr_d;
      reading_q        <= reading_d;
      rd_valid_q       <= rd_valid_d;
      rd_last_q        <= rd_last_d;
      out_last_q       <= out_last_d;
      enable_q         <= enable_d;
      pix_q            <= pix_d;
      done_q           <= done_d;
      tcnt_q           <= tcnt_d;
      frame_complete_q <= frame_complete_d;
      timeout_q        <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    busy_d           = busy_q;
    addr_d           = addr_q;
    reading_d        = reading_q;
    tcnt_d           = '0;
    frame_complete_d = 1'b0;
    timeout_d        = 1'b0;

    // PRIME issues the read for pixel 0. STREAM issues the rest until the
    // last address has been read.
    rd_en_w = (state_q == S_PRIME) || ((state_q == S_STREAM) && reading_q);

    // The read pipeline runs every cycle. Outputs are zero whenever the RAM
    // data of the previous cycle was not a requested pixel.
    rd_valid_d  = rd_en_w;
    rd_last_d   = rd_en_w && (addr_q == LAST_ADDR);
    out_last_d  = rd_last_q;
    pix_d       = rd_valid_q ? mem_rdata : '0;

    // enable goes out the cycle after PRIME, one cycle before pixel 0.
    enable_d    = (state_q == S_PRIME);

    // done_in is sampled every cycle, so a level that is already high when
    // WAIT_RESULT is entered is not mistaken for a rising edge.
    done_d      = done_in;
    done_rise_w = done_in && !done_q;

    unique case (state_q)
      S_IDLE: begin
        addr_d    = '0;
        reading_d = 1'b0;
        if (start) begin
          state_d = S_PRIME;
          busy_d  = 1'b1;
        end
      end

      S_PRIME: begin
        state_d = S_STREAM;
        if (addr_q == LAST_ADDR) begin
          reading_d = 1'b0;
        end else begin
          reading_d = 1'b1;
          addr_d    = addr_q + 1'b1;
        end
      end

      S_STREAM: begin
        // The address holds at the last pixel rather than wrapping.
        if (reading_q) begin
          if (addr_q == LAST_ADDR) begin
            reading_d = 1'b0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
        // Leave once the last pixel is on the outputs. DRAIN is then the
        // zero end-of-image cycle.
        if (out_last_q) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        state_d   = S_WAIT;
        addr_d    = '0;
        reading_d = 1'b0;
      end

      S_WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        // If an edge and expiry land in the same cycle, completion takes priority.
        if (done_rise_w) begin
          state_d          = S_IDLE;
          busy_d           = 1'b0;
          frame_complete_d = 1'b1;
          tcnt_d           = '0;
        end else if (tcnt_q == TCNT_LAST) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          tcnt_d    = '0;
        end
      end

      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        addr_d    = '0;
        reading_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy           = busy_q;
  assign mem_rd_en      = rd_en_w;
  assign mem_addr       = rd_en_w ? addr_q : '0;
  assign image_out_R    = pix_q[PIX_W-1 -: COLOR_DEPTH];
  assign image_out_G    = pix_q[2*COLOR_DEPTH-1 -: COLOR_DEPTH];
  assign image_out_B    = pix_q[COLOR_DEPTH-1:0];
  assign enable         = enable_q;
  assign frame_complete = frame_complete_q;
  assign timeout        = timeout_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_face_image_sender.sv
// -----------------------------------------------------------------------------
// Directed bench for face_image_sender using a 4x2 frame and a 16-cycle timeout.
// A 1-cycle-latency RAM model holds RAM[k] = {k, k+1, k+2}. Outputs are sampled
// 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_face_image_sender;

  localparam int WIDTH   = 4;
  localparam int DEPTH   = 2;
  localparam int CD      = 8;
  localparam int ADDR_W  = 3;
  localparam int TMO     = 16;
  localparam int NPIX    = WIDTH * DEPTH;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRIME  = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [3*CD-1:0]   mem_rdata;
  logic [CD-1:0]     image_out_R;
  logic [CD-1:0]     image_out_G;
  logic [CD-1:0]     image_out_B;
  logic              enable;
  logic              done_in;
  logic              frame_complete;
  logic              timeout;
  logic [2:0]        state_dbg;

  int vectors;
  int miscompares;

  logic [3*CD-1:0] ram [0:NPIX-1];

  face_image_sender #(
    .WIDTH          (WIDTH),
    .DEPTH          (DEPTH),
    .COLOR_DEPTH    (CD),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .image_out_R    (image_out_R),
    .image_out_G    (image_out_G),
    .image_out_B    (image_out_B),
    .enable         (enable),
    .done_in        (done_in),
    .frame_complete (frame_complete),
    .timeout        (timeout),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame RAM model, one cycle of read latency
  initial begin
    for (int k = 0; k < NPIX; k++) ram[k] = pix(k);
  end

  always_ff @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  // ---------------- helpers ----------------
  function automatic logic [3*CD-1:0] pix(input int k);
    logic [CD-1:0] r, g, b;
    r = CD'(k);
    g = CD'(k + 1);
    b = CD'(k + 2);
    return {r, g, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " state"},  32'(state_dbg), 32'(ST_IDLE));
    check({tag, " busy"},   32'(busy), 32'd0);
    check({tag, " rd_en"},  32'(mem_rd_en), 32'd0);
    check({tag, " addr"},   32'(mem_addr), 32'd0);
    check({tag, " enable"}, 32'(enable), 32'd0);
    check({tag, " pixel"},  32'({image_out_R, image_out_G, image_out_B}), 32'd0);
    check({tag, " fc"},     32'(frame_complete), 32'd0);
    check({tag, " tmo"},    32'(timeout), 32'd0);
  endtask

  // Pulses start, then checks each cycle from PRIME (c=0) through DRAIN
  // (c=NPIX+2). It returns in the first WAIT_RESULT cycle (W0).
  task automatic send_and_check_frame(input string tag, input bit hold_start);
    logic [3*CD-1:0] exp_pix;
    start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    for (int c = 0; c <= NPIX + 2; c++) begin
      exp_pix = (c >= 2 && c <= NPIX + 1) ? pix(c - 2) : '0;
      check($sformatf("%s pix c=%0d", tag, c),
            32'({image_out_R, image_out_G, image_out_B}), 32'(exp_pix));
      check($sformatf("%s enable c=%0d", tag, c), 32'(enable), 32'(c == 1));
      check($sformatf("%s rd_en c=%0d", tag, c), 32'(mem_rd_en), 32'(c < NPIX));
      if (c < NPIX)
        check($sformatf("%s addr c=%0d", tag, c), 32'(mem_addr), 32'(c));
      check($sformatf("%s busy c=%0d", tag, c), 32'(busy), 32'd1);
      check($sformatf("%s state c=%0d", tag, c), 32'(state_dbg),
            32'((c == 0) ? ST_PRIME : (c <= NPIX + 1) ? ST_STREAM : ST_DRAIN));
      tick();
    end
    start = 1'b0;
    check({tag, " W0 state"}, 32'(state_dbg), 32'(ST_WAIT));
    check({tag, " W0 busy"}, 32'(busy), 32'd1);
  endtask

  // From W0: raise done_in at W<n>, then expect a completion pulse one cycle later.
  task automatic expect_complete(input string tag, input int n);
    for (int i = 0; i < n; i++) tick();
    done_in = 1'b1;
    tick();
    check({tag, " fc"},    32'(frame_complete), 32'd1);
    check({tag, " tmo"},   32'(timeout), 32'd0);
    check({tag, " busy"},  32'(busy), 32'd0);
    check({tag, " state"}, 32'(state_dbg), 32'(ST_IDLE));
    tick();
    check({tag, " fc drop"}, 32'(frame_complete), 32'd0);
  endtask

  // From W0: with no done edge, expect the timeout pulse after exactly TMO cycles.
  task automatic expect_timeout(input string tag);
    for (int i = 1; i < TMO; i++) tick();
    check({tag, " W15 state"}, 32'(state_dbg), 32'(ST_WAIT));
    check({tag, " W15 tmo"}, 32'(timeout), 32'd0);
    tick();
    check({tag, " tmo"},   32'(timeout), 32'd1);
    check({tag, " fc"},    32'(frame_complete), 32'd0);
    check({tag, " busy"},  32'(busy), 32'd0);
    check({tag, " state"}, 32'(state_dbg), 32'(ST_IDLE));
    tick();
    check({tag, " tmo drop"}, 32'(timeout), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    done_in     = 1'b0;

    // Reset state
    tick();
    tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
    check_idle_outputs("post_reset");

    // Full frame, then done rises 10 cycles into WAIT_RESULT
    send_and_check_frame("frame1", 1'b0);
    expect_complete("done10", 10);
    done_in = 1'b0;
    tick();

    // Timeout with done_in held low
    send_and_check_frame("frame2", 1'b0);
    expect_timeout("tmo16");

    // start held high for the whole frame: only one frame is sent
    send_and_check_frame("held", 1'b1);
    expect_complete("held_done", 3);
    done_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("no_refire state i=%0d", i), 32'(state_dbg), 32'(ST_IDLE));
      check($sformatf("no_refire enable i=%0d", i), 32'(enable), 32'd0);
    end
    send_and_check_frame("restart", 1'b0);
    expect_complete("restart_done", 1);
    done_in = 1'b0;
    tick();

    // Asynchronous reset in the middle of STREAM
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_reset state", 32'(state_dbg), 32'(ST_STREAM));
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    tick();
    rst_n = 1'b1;
    tick();
    send_and_check_frame("after_reset", 1'b0);
    expect_complete("after_reset_done", 0);
    done_in = 1'b0;
    tick();

    // done_in already high on entry is not an edge, so the timeout fires
    done_in = 1'b1;
    tick();
    send_and_check_frame("done_high", 1'b0);
    expect_timeout("done_high_tmo");

    // done_in high on entry, then low, then high: this completes the frame
    send_and_check_frame("lohi", 1'b0);
    done_in = 1'b0;
    tick();
    check("lohi W1 state", 32'(state_dbg), 32'(ST_WAIT));
    check("lohi W1 fc", 32'(frame_complete), 32'd0);
    expect_complete("lohi_done", 1);
    done_in = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
